// File: rtl/calc_pkg.sv
// Shared types and constants for the binary-to-BCD converter.
package calc_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } bcd_state_t;

    localparam int unsigned DIGIT_W        = 4;
    localparam int unsigned BCD_ADJ_THRESH = 5;

    // 10^n, used to check at elaboration that DIGITS covers the input range
    function automatic logic [63:0] pow10(input int unsigned n);
        logic [63:0] r;
        r = 64'd1;
        for (int unsigned i = 0; i < n; i++) begin
            r = r * 64'd10;
        end
        return r;
    endfunction

endpackage

// File: rtl/bcd_digit_adj.sv
// Double-dabble digit correction: adds 3 to a BCD digit of 5 or more before the shift.
module bcd_digit_adj
    import calc_pkg::*;
(
    input  logic [3:0] digit,
    output logic [3:0] adj_c
);

    always_comb begin
        adj_c = digit;
        if (digit >= DIGIT_W'(BCD_ADJ_THRESH)) begin
            adj_c = digit + DIGIT_W'(3);
        end
    end

endmodule

// File: rtl/bin_to_bcd.sv
// Sequential binary-to-BCD converter (double-dabble, one bit per clock, MSB first).
// Define BIN_TO_BCD_SIGNED_EN to treat bin_in as two's complement and report sign_out.
module bin_to_bcd
    import calc_pkg::*;
#(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned DIGITS = 3
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [DATA_W-1:0]       bin_in,
    output logic                    busy,
    output logic                    done,
    output logic [DIGIT_W*DIGITS-1:0] bcd_out,
    output logic                    sign_out
);

    localparam int unsigned BCD_W = DIGIT_W * DIGITS;
    localparam int unsigned CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    if (pow10(DIGITS) <= ((64'd1 << DATA_W) - 64'd1)) begin : g_bad_digits
        $error("bin_to_bcd: DIGITS too small for DATA_W");
    end

    bcd_state_t          state;
    bcd_state_t          next_state;
    logic [BCD_W-1:0]    scratch;
    logic [BCD_W-1:0]    adj_c;
    logic [DATA_W-1:0]   operand;
    logic [DATA_W-1:0]   load_c;
    logic [CNT_W-1:0]    cnt;

    for (genvar g = 0; g < int'(DIGITS); g++) begin : g_adj
        bcd_digit_adj u_adj (
            .digit (scratch[g*DIGIT_W +: DIGIT_W]),
            .adj_c (adj_c[g*DIGIT_W +: DIGIT_W])
        );
    end

`ifdef BIN_TO_BCD_SIGNED_EN
    logic sign_pend;

    // Magnitude of a two's-complement input; the most negative value maps to 2^(DATA_W-1)
    assign load_c = bin_in[DATA_W-1] ? (~bin_in + DATA_W'(1)) : bin_in;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sign_pend <= 1'b0;
            sign_out  <= 1'b0;
        end else begin
            if (state == IDLE && start) begin
                sign_pend <= bin_in[DATA_W-1];
            end
            if (state == DONE) begin
                sign_out <= sign_pend;
            end
        end
    end
`else
    assign load_c   = bin_in;
    assign sign_out = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (start) next_state = SHIFT;
            SHIFT:   if (cnt == CNT_W'(DATA_W - 1)) next_state = DONE;
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Datapath and registered outputs; done and bcd_out update on leaving DONE
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            scratch <= '0;
            operand <= '0;
            cnt     <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            bcd_out <= '0;
        end else begin
            busy <= (next_state != IDLE);
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        operand <= load_c;
                        scratch <= '0;
                        cnt     <= '0;
                    end
                end
                SHIFT: begin
                    {scratch, operand} <= {adj_c, operand} << 1;
                    cnt                <= cnt + CNT_W'(1);
                end
                DONE: begin
                    bcd_out <= scratch;
                    done    <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_bin_to_bcd.sv
// Directed self-checking bench for bin_to_bcd (DATA_W=8, DIGITS=3).
module tb_bin_to_bcd;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [7:0]  bin_in;
    logic        busy;
    logic        done;
    logic [11:0] bcd_out;
    logic        sign_out;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    bin_to_bcd #(.DATA_W(8), .DIGITS(3)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .bin_in   (bin_in),
        .busy     (busy),
        .done     (done),
        .bcd_out  (bcd_out),
        .sign_out (sign_out)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One isolated conversion; returns in IDLE, 1ns after an edge
    task automatic run_conv(input string tag, input logic [7:0] val,
                            input logic [11:0] exp_bcd, input logic exp_sign);
        int          done_at;
        int          n_done;
        logic        held;
        logic [11:0] prev;
        prev    = bcd_out;
        held    = 1'b1;
        done_at = -1;
        n_done  = 0;
        start   = 1'b1;
        bin_in  = val;
        step();
        start  = 1'b0;
        bin_in = 8'hA5;
        check({tag, "_busy"}, 32'(busy), 32'd1);
        for (int k = 0; k < 14; k++) begin
            if (done) begin
                n_done++;
                if (done_at < 0) done_at = k;
            end
            if (k < 9 && bcd_out !== prev) held = 1'b0;
            step();
        end
        check({tag, "_latency"}, 32'(done_at), 32'd9);
        check({tag, "_ndone"},   32'(n_done),  32'd1);
        check({tag, "_bcd"},     32'(bcd_out), 32'(exp_bcd));
        check({tag, "_sign"},    32'(sign_out), 32'(exp_sign));
        check({tag, "_hold"},    32'(held),    32'd1);
        check({tag, "_idle"},    32'(busy),    32'd0);
    endtask

    initial begin
        int done_at;
        int n_done;
        int times[3];

        rst    = 1'b0;
        start  = 1'b0;
        bin_in = 8'h00;
        repeat (3) step();
        check("rst_busy", 32'(busy),     32'd0);
        check("rst_done", 32'(done),     32'd0);
        check("rst_bcd",  32'(bcd_out),  32'd0);
        check("rst_sign", 32'(sign_out), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        step();

        run_conv("zero", 8'h00, 12'h000, 1'b0);
`ifdef BIN_TO_BCD_SIGNED_EN
        run_conv("ff",  8'hFF, 12'h001, 1'b1);
        run_conv("x80", 8'h80, 12'h128, 1'b1);
`else
        run_conv("ff",  8'hFF, 12'h255, 1'b0);
        run_conv("x80", 8'h80, 12'h128, 1'b0);
`endif
        run_conv("x7f", 8'h7F, 12'h127, 1'b0);

        // Requests sampled mid-SHIFT and in the DONE cycle are dropped
        start  = 1'b1;
        bin_in = 8'h7B;
        step();
        n_done  = 0;
        done_at = -1;
        for (int k = 0; k < 25; k++) begin
            if (done) begin
                n_done++;
                if (done_at < 0) done_at = k;
            end
            start  = (k == 2 || k == 8);
            bin_in = start ? 8'h01 : 8'h5A;
            step();
        end
        start = 1'b0;
        check("ign_ndone",   32'(n_done),  32'd1);
        check("ign_latency", 32'(done_at), 32'd9);
        check("ign_bcd",     32'(bcd_out), 32'h123);
        check("ign_idle",    32'(busy),    32'd0);

        // Asynchronous reset mid-conversion
        start  = 1'b1;
        bin_in = 8'h63;
        step();
        start = 1'b0;
        repeat (3) step();
        check("abort_busy_pre", 32'(busy), 32'd1);
        #2 rst = 1'b0;
        #1;
        check("abort_busy", 32'(busy),     32'd0);
        check("abort_done", 32'(done),     32'd0);
        check("abort_bcd",  32'(bcd_out),  32'd0);
        check("abort_sign", 32'(sign_out), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        step();
        n_done = 0;
        for (int k = 0; k < 12; k++) begin
            if (done || busy) n_done++;
            step();
        end
        check("abort_quiet", 32'(n_done), 32'd0);
        run_conv("reconv", 8'h63, 12'h099, 1'b0);

        // start held high: one conversion every DATA_W+2 cycles
        start  = 1'b1;
        bin_in = 8'h2A;
        step();
        n_done = 0;
        for (int k = 0; k < 32; k++) begin
            if (done) begin
                if (n_done < 3) times[n_done] = k;
                n_done++;
                check("b2b_bcd", 32'(bcd_out), 32'h042);
            end
            step();
        end
        start = 1'b0;
        check("b2b_ndone", 32'(n_done),   32'd3);
        check("b2b_t0",    32'(times[0]), 32'd9);
        check("b2b_t1",    32'(times[1]), 32'd19);
        check("b2b_t2",    32'(times[2]), 32'd29);
        repeat (12) step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
